pc_gen_multi: RTL and testbench

//  Parametrised PRE_IF next-PC generator replacing the combinational PC-select + PC register pair.

---
 rtl/pcgen_pkg.sv | 24 ++
 rtl/redirect_arbiter.sv | 29 ++
 rtl/pc_gen_multi.sv | 132 +++++++++++++
 tb/tb_pc_gen_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcgen_pkg.sv
// Shared types and encodings for the pre-IF next-PC generator.
// Source codes on pc_src_o and the generator FSM states.
package pcgen_pkg;

  localparam int SRC_SEQ        = 0;
  localparam int SRC_BPU        = 1;
  localparam int SRC_PEND       = 2;
  localparam int SRC_REDIR_BASE = 3;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    PEND
  } pcg_state_e;

  function automatic int src_w(input int n);
    return $clog2(n + 3);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority pick among redirect sources.
// Index 0 wins; reports any/index/target.
module redirect_arbiter
  import pcgen_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]    i_valid,
  input  logic [N*32-1:0] i_pc,
  output logic            o_any,
  output logic [IW-1:0]   o_idx,
  output logic [31:0]     o_pc
);

  always_comb begin
    o_any = |i_valid;
    o_idx = '0;
    o_pc  = '0;
    // walk high to low so the lowest set index is the last write
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_idx = IW'(i);
        o_pc  = i_pc[32*i +: 32];
      end
    end
  end

endmodule

// File: rtl/pc_gen_multi.sv
// Fetch PC register with prioritised redirects, BPU and sequential fetch.
// Redirects seen while IF stalls are buffered and squash the stale fetch.
module pc_gen_multi
  import pcgen_pkg::*;
#(
  parameter int          NUM_REDIRECT = 4,
  parameter int          FETCH_WIDTH  = 1,
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [NUM_REDIRECT-1:0]        redirect_valid,
  input  logic [NUM_REDIRECT*32-1:0]     redirect_pc,
  input  logic                           bpu_valid,
  input  logic [31:0]                    bpu_target,
  input  logic                           if_ready,
  output logic [31:0]                    pc_o,
  output logic                           pc_valid_o,
  output logic [src_w(NUM_REDIRECT)-1:0] pc_src_o,
  output logic                           squash_o,
  output logic                           pend_o
);

  localparam int          SRCW = src_w(NUM_REDIRECT);
  localparam int          IW   = idx_w(NUM_REDIRECT);
  localparam logic [31:0] FB   = 32'(4 * FETCH_WIDTH);

  pcg_state_e      r_state;
  pcg_state_e      w_nstate;
  logic [31:0]     r_pc;
  logic [31:0]     w_npc;
  logic [SRCW-1:0] r_src;
  logic [SRCW-1:0] w_nsrc;
  logic [31:0]     r_pend_pc;
  logic [31:0]     w_npend_pc;
  logic [SRCW-1:0] r_pend_src;
  logic [SRCW-1:0] w_npend_src;
  logic            w_squash;

  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic [31:0]     w_win_pc;
  logic [SRCW-1:0] w_win_src;
  logic [31:0]     w_seq;

  redirect_arbiter #(
    .N  (NUM_REDIRECT),
    .IW (IW)
  ) u_arb (
    .i_valid (redirect_valid),
    .i_pc    (redirect_pc),
    .o_any   (w_any),
    .o_idx   (w_idx),
    .o_pc    (w_win_pc)
  );

  assign w_win_src = SRCW'(SRC_REDIR_BASE) + SRCW'(w_idx);
  assign w_seq     = (r_pc & ~(FB - 32'd1)) + FB;

  always_comb begin
    w_nstate    = r_state;
    w_npc       = r_pc;
    w_nsrc      = r_src;
    w_npend_pc  = r_pend_pc;
    w_npend_src = r_pend_src;
    w_squash    = 1'b0;
    unique case (r_state)
      BOOT: w_nstate = RUN;
      RUN: begin
        if (if_ready) begin
          if (w_any) begin
            w_npc  = w_win_pc;
            w_nsrc = w_win_src;
          end else if (bpu_valid) begin
            w_npc  = bpu_target;
            w_nsrc = SRCW'(SRC_BPU);
          end else begin
            w_npc  = w_seq;
            w_nsrc = SRCW'(SRC_SEQ);
          end
        end else if (w_any) begin
          w_npend_pc  = w_win_pc;
          w_npend_src = w_win_src;
          w_nstate    = PEND;
        end
      end
      PEND: begin
        if (if_ready) begin
          w_squash    = 1'b1;
          w_nstate    = RUN;
          w_npend_pc  = '0;
          w_npend_src = SRCW'(SRC_PEND);
          if (w_any) begin
            w_npc  = w_win_pc;
            w_nsrc = w_win_src;
          end else begin
            w_npc  = r_pend_pc;
            w_nsrc = r_pend_src;
          end
        end else if (w_any) begin
          // newest redirect supersedes whatever is buffered
          w_npend_pc  = w_win_pc;
          w_npend_src = w_win_src;
        end
      end
      default: w_nstate = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_src      <= SRCW'(SRC_SEQ);
      r_pend_pc  <= '0;
      r_pend_src <= SRCW'(SRC_PEND);
    end else begin
      r_state    <= w_nstate;
      r_pc       <= w_npc;
      r_src      <= w_nsrc;
      r_pend_pc  <= w_npend_pc;
      r_pend_src <= w_npend_src;
    end
  end

  assign pc_o       = r_pc;
  assign pc_src_o   = r_src;
  assign pc_valid_o = (r_state != BOOT);
  assign pend_o     = (r_state == PEND);
  assign squash_o   = w_squash;

endmodule

// File: tb/tb_pc_gen_multi.sv
// Scoreboard bench for pc_gen_multi: FW=2 main instance,
// FW=1 instance for wrap and misaligned-target cases.
module tb_pc_gen_multi;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   rv;
  logic [127:0] rp;
  logic         bpu_v;
  logic [31:0]  bpu_t;
  logic         rdy;
  logic [31:0]  pc;
  logic         pv;
  logic [2:0]   src;
  logic         sq;
  logic         pd;

  logic [3:0]   rv1;
  logic [127:0] rp1;
  logic         bv1;
  logic [31:0]  bt1;
  logic         rdy1;
  logic [31:0]  pc1;
  logic         pv1;
  logic [2:0]   src1;
  logic         sq1;
  logic         pd1;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  src;
    logic        v;
    logic        pd;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_gen_multi #(
    .NUM_REDIRECT (4),
    .FETCH_WIDTH  (2),
    .RESET_PC     (32'hBFC0_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (rv),
    .redirect_pc    (rp),
    .bpu_valid      (bpu_v),
    .bpu_target     (bpu_t),
    .if_ready       (rdy),
    .pc_o           (pc),
    .pc_valid_o     (pv),
    .pc_src_o       (src),
    .squash_o       (sq),
    .pend_o         (pd)
  );

  pc_gen_multi #(
    .NUM_REDIRECT (4),
    .FETCH_WIDTH  (1),
    .RESET_PC     (32'hBFC0_0000)
  ) dut1 (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (rv1),
    .redirect_pc    (rp1),
    .bpu_valid      (bv1),
    .bpu_target     (bt1),
    .if_ready       (rdy1),
    .pc_o           (pc1),
    .pc_valid_o     (pv1),
    .pc_src_o       (src1),
    .squash_o       (sq1),
    .pend_o         (pd1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [3:0] v,
                     input logic b, input logic [31:0] bt,
                     input logic [31:0] epc, input logic [2:0] esrc,
                     input logic esq, input logic epd);
    exp_t x;
    exp_t e;
    rdy   = r;
    rv    = v;
    bpu_v = b;
    bpu_t = bt;
    #1;
    chk({tag, ".squash"}, 32'(sq), 32'(esq));
    x.pc  = epc;
    x.src = esrc;
    x.v   = 1'b1;
    x.pd  = epd;
    x.tag = tag;
    q0.push_back(x);
    @(posedge clk);
    #1;
    if (q0.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = q0.pop_front();
      chk({e.tag, ".pc"}, pc, e.pc);
      chk({e.tag, ".src"}, 32'(src), 32'(e.src));
      chk({e.tag, ".valid"}, 32'(pv), 32'(e.v));
      chk({e.tag, ".pend"}, 32'(pd), 32'(e.pd));
    end
    rv    = '0;
    bpu_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc1(input string tag, input logic [3:0] v,
                      input logic [31:0] epc, input logic [2:0] esrc);
    exp_t x;
    exp_t e;
    rdy1 = 1'b1;
    rv1  = v;
    #1;
    chk({tag, ".squash"}, 32'(sq1), 32'd0);
    x.pc  = epc;
    x.src = esrc;
    x.v   = 1'b1;
    x.pd  = 1'b0;
    x.tag = tag;
    q1.push_back(x);
    @(posedge clk);
    #1;
    if (q1.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = q1.pop_front();
      chk({e.tag, ".pc"}, pc1, e.pc);
      chk({e.tag, ".src"}, 32'(src1), 32'(e.src));
      chk({e.tag, ".valid"}, 32'(pv1), 32'(e.v));
    end
    rv1  = '0;
    rdy1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_rp(input int k, input logic [31:0] a);
    rp[32*k +: 32] = a;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".pc"}, pc, 32'hBFC0_0000);
    chk({tag, ".valid"}, 32'(pv), 32'd0);
    chk({tag, ".src"}, 32'(src), 32'd0);
    chk({tag, ".squash"}, 32'(sq), 32'd0);
    chk({tag, ".pend"}, 32'(pd), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    rv     = '0;
    rp     = '0;
    bpu_v  = 1'b0;
    bpu_t  = '0;
    rdy    = 1'b1;
    rv1    = '0;
    rp1    = '0;
    bv1    = 1'b0;
    bt1    = '0;
    rdy1   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    resetn = 1'b1;

    set_rp(0, 32'h1234_5678);
    cyc("boot", 1, 4'b0001, 0, 0, 32'hBFC0_0000, 3'd0, 0, 0);
    cyc("seq1", 1, 4'b0000, 0, 0, 32'hBFC0_0008, 3'd0, 0, 0);
    cyc("seq2", 1, 4'b0000, 0, 0, 32'hBFC0_0010, 3'd0, 0, 0);

    set_rp(0, 32'hBFC0_0004);
    cyc("mis", 1, 4'b0001, 0, 0, 32'hBFC0_0004, 3'd3, 0, 0);
    cyc("align", 1, 4'b0000, 0, 0, 32'hBFC0_0008, 3'd0, 0, 0);

    set_rp(1, 32'h8000_2000);
    set_rp(3, 32'hA000_0000);
    cyc("prio", 1, 4'b1010, 1, 32'h8000_1000, 32'h8000_2000, 3'd4, 0, 0);
    cyc("bpu", 1, 4'b0000, 1, 32'h8000_1000, 32'h8000_1000, 3'd1, 0, 0);
    cyc("bseq", 1, 4'b0000, 0, 0, 32'h8000_1008, 3'd0, 0, 0);

    cyc("stbpu", 0, 4'b0000, 1, 32'hDEAD_0000, 32'h8000_1008, 3'd0, 0, 0);
    cyc("rel", 1, 4'b0000, 0, 0, 32'h8000_1010, 3'd0, 0, 0);

    set_rp(0, 32'hBFC0_0380);
    cyc("p4.c1", 0, 4'b0000, 0, 0, 32'h8000_1010, 3'd0, 0, 0);
    cyc("p4.c2", 0, 4'b1000, 0, 0, 32'h8000_1010, 3'd0, 0, 1);
    cyc("p4.c3", 0, 4'b0001, 0, 0, 32'h8000_1010, 3'd0, 0, 1);
    cyc("p4.c4", 0, 4'b0000, 0, 0, 32'h8000_1010, 3'd0, 0, 1);
    cyc("p4.c5", 1, 4'b0000, 1, 32'h8000_1000,
        32'hBFC0_0380, 3'd3, 1, 0);

    set_rp(0, 32'h1111_0000);
    set_rp(2, 32'h2222_0000);
    cyc("new.a", 0, 4'b0001, 0, 0, 32'hBFC0_0380, 3'd3, 0, 1);
    cyc("new.b", 0, 4'b0100, 0, 0, 32'hBFC0_0380, 3'd3, 0, 1);
    cyc("new.r", 1, 4'b0000, 0, 0, 32'h2222_0000, 3'd5, 1, 0);

    set_rp(1, 32'h3333_0000);
    set_rp(3, 32'h4444_0000);
    cyc("pr.a", 0, 4'b0010, 0, 0, 32'h2222_0000, 3'd5, 0, 1);
    cyc("pr.r", 1, 4'b1000, 1, 32'h8000_1000,
        32'h4444_0000, 3'd6, 1, 0);

    set_rp(0, 32'h5555_0000);
    cyc("rp.a", 0, 4'b0001, 0, 0, 32'h4444_0000, 3'd6, 0, 1);
    #2;
    resetn = 1'b0;
    #1;
    reset_checks("rstpend");
    @(negedge clk);
    resetn = 1'b1;
    rdy    = 1'b1;
    cyc("boot2", 1, 4'b0000, 0, 0, 32'hBFC0_0000, 3'd0, 0, 0);
    cyc("seq3", 1, 4'b0000, 0, 0, 32'hBFC0_0008, 3'd0, 0, 0);

    rp1[31:0] = 32'hFFFF_FFFC;
    cyc1("w.top", 4'b0001, 32'hFFFF_FFFC, 3'd3);
    cyc1("w.wrap", 4'b0000, 32'h0000_0000, 3'd0);
    cyc1("w.seq", 4'b0000, 32'h0000_0004, 3'd0);
    rp1[31:0] = 32'h0000_0102;
    cyc1("w.mis", 4'b0001, 32'h0000_0102, 3'd3);
    cyc1("w.aln", 4'b0000, 32'h0000_0104, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
